regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised general-purpose register file for the single-cycle/multi-cycle CPU datapath. It provides two combinational read ports and one write-back port. It also has a dedicated external-input write channel into a fixed register, a registered monitor tap of a fixed register, and a per-register busy scoreboard that raises a stall when a source operand is still waiting on an outstanding multi-cycle load.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; register count = 2**ADDR_W
EXT_REG, 25, index written by the external-input channel
MON_REG, 24, index copied to the monitor output

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rs_addr  input  ADDR_W  read port A index
rt_addr  input  ADDR_W  read port B index
rs_data  output  DATA_W  read port A data (combinational)
rt_data  output  DATA_W  read port B data (combinational)
wr_en  input  1  write-back enable
wr_addr  input  ADDR_W  write-back index
wr_data  input  DATA_W  write-back data
ext_wr_en  input  1  external-input write enable
ext_wr_data  input  DATA_W  external-input data for EXT_REG
busy_set  input  1  load issued; mark busy_addr pending
busy_addr  input  ADDR_W  destination of the issued load
stall  output  1  source operand pending (combinational)
mon_data  output  DATA_W  registered copy of MON_REG

Behaviour:
- Reset (reset==0, async): all registers, all busy bits and mon_data go to 0 immediately. Reset held across edges keeps them at 0. Release is synchronous to the next rising edge.
- Register 0: always reads 0. Writes to it are discarded, including ext writes if EXT_REG==0. It can never be busy; busy_set with busy_addr==0 is ignored.
- Write-back: if wr_en and wr_addr!=0, regs[wr_addr] <= wr_data on the rising edge.
- External write: if ext_wr_en, regs[EXT_REG] <= ext_wr_data on the rising edge.
- Simultaneous wr_en to EXT_REG and ext_wr_en: the write-back port wins and the ext data is dropped.
- Reads: rs_data = regs[rs_addr] and rt_data = regs[rt_addr], combinational, with zero-cycle latency from address.
- Scoreboard:
  - busy[busy_addr] <= 1 on an edge where busy_set is high.
  - busy[wr_addr] <= 0 on an edge where wr_en is high.
  - Same address set and cleared in the same cycle: set wins (new load overrides retiring one).
  - ext writes do not affect busy bits.
- stall = (busy[rs_addr] && rs_addr!=0) || (busy[rt_addr] && rt_addr!=0). No registering; the pipeline holds while stall==1.
- Monitor: mon_data <= regs[MON_REG] every rising edge, using the pre-update value. A write to MON_REG appears on mon_data two edges after it is presented.
- Out-of-range indices cannot occur (the full 2**ADDR_W range is populated).

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding. If wr_en && wr_addr!=0 && wr_addr==rs_addr, then rs_data = wr_data in the same cycle; the same rule applies to rt.
  - A read of EXT_REG while ext_wr_en is high and no wr_en targets EXT_REG returns ext_wr_data.
  - stall ignores a busy bit being cleared in that same cycle by wr_en (operand is forwarded).
- Undefined:
  - Reads always return stored contents.
  - stall reflects the current busy bits only.

Test Plan:
- Async reset mid-operation: write 0xDEADBEEF to r5, then pull reset low between edges -> rs_data(r5)=0, mon_data=0 and stall=0 immediately, with no clock edge needed.
- r0 protection: wr_en, wr_addr=0, wr_data=0xFFFFFFFF -> rs_data(r0)=0. busy_set with busy_addr=0 then rs_addr=0 -> stall=0.
- Write/read: write 0x12345678 to r8, read rs=8 and rt=8 next cycle -> both 0x12345678. With REGFILE_BYPASS_EN, the same cycle as the write also shows 0x12345678.
- External-write priority: ext_wr_en with 0xAAAA0000 alone -> r25=0xAAAA0000. Same cycle wr_en to r25 with 0x5555 and ext 0xAAAA -> r25=0x5555.
- Scoreboard:
  - busy_set r9, then rt_addr=9 -> stall=1.
  - wr_en to r9 -> stall=0 after the edge (without bypass) or in the same cycle (with bypass).
  - Simultaneous busy_set r9 and wr_en r9 -> stall remains 1.
- Monitor lag: write 0x00000042 to r24 at edge N -> mon_data=0x42 after edge N+1, and still the old value after edge N.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register-file access bundle: read ports, write-back, external write, scoreboard set, status outputs.
// Latency: none (pure wiring); the register file defines all timing.
// Backpressure: none on this bundle; the consumer holds while stall is high.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              ext_wr_en;
    logic [DATA_W-1:0] ext_wr_data;
    logic              busy_set;
    logic [ADDR_W-1:0] busy_addr;
    logic              stall;
    logic [DATA_W-1:0] mon_data;

    // Datapath side: drives indices and write traffic, consumes read data and status.
    modport master (
        output rs_addr, rt_addr, wr_en, wr_addr, wr_data,
        output ext_wr_en, ext_wr_data, busy_set, busy_addr,
        input  rs_data, rt_data, stall, mon_data
    );

    // Register file side.
    modport slave (
        input  rs_addr, rt_addr, wr_en, wr_addr, wr_data,
        input  ext_wr_en, ext_wr_data, busy_set, busy_addr,
        output rs_data, rt_data, stall, mon_data
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with 2 read ports, write-back, external-input write, monitor tap and load scoreboard.
// Latency: reads/stall combinational, writes land on the next edge, mon_data lags a write by two edges.
// Backpressure: stall is raised while a read operand waits on an outstanding load; REGFILE_BYPASS_EN adds forwarding.
module regfile_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int EXT_REG = 25,
    parameter int MON_REG = 24
) (
    input  logic          clock,
    input  logic          reset,
    regfile_sb_if.slave   bus
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] EXT_A = ADDR_W'(EXT_REG);
    localparam logic [ADDR_W-1:0] MON_A = ADDR_W'(MON_REG);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [DATA_W-1:0] mon_q;

    // An ext write is dropped whenever the write-back port targets the same register.
    logic ext_take;
    assign ext_take = bus.ext_wr_en && (EXT_A != '0) && !(bus.wr_en && bus.wr_addr == EXT_A);

    // Register storage: write-back has priority over the external channel, register 0 never changes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (bus.wr_en && bus.wr_addr == ADDR_W'(i)) begin
                    regs[i] <= bus.wr_data;
                end else if (ext_take && EXT_A == ADDR_W'(i)) begin
                    regs[i] <= bus.ext_wr_data;
                end
            end
        end
    end

    // Scoreboard: a newly issued load overrides a retiring one on the same register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (bus.busy_set && bus.busy_addr == ADDR_W'(i)) begin
                    busy[i] <= 1'b1;
                end else if (bus.wr_en && bus.wr_addr == ADDR_W'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
            busy[0] <= 1'b0;
        end
    end

    // Monitor tap samples the pre-update contents every edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mon_q <= '0;
        end else begin
            mon_q <= regs[MON_A];
        end
    end

    assign bus.mon_data = mon_q;

`ifdef REGFILE_BYPASS_EN
    // Read muxes with write-through forwarding of the write-back and external channels.
    always_comb begin
        bus.rs_data = regs[bus.rs_addr];
        bus.rt_data = regs[bus.rt_addr];
        if (bus.wr_en && bus.wr_addr != '0 && bus.wr_addr == bus.rs_addr) begin
            bus.rs_data = bus.wr_data;
        end else if (ext_take && bus.rs_addr == EXT_A) begin
            bus.rs_data = bus.ext_wr_data;
        end
        if (bus.wr_en && bus.wr_addr != '0 && bus.wr_addr == bus.rt_addr) begin
            bus.rt_data = bus.wr_data;
        end else if (ext_take && bus.rt_addr == EXT_A) begin
            bus.rt_data = bus.ext_wr_data;
        end
    end

    // A busy bit being retired this cycle does not stall: its value is forwarded.
    logic rs_clr, rt_clr;
    always_comb begin
        rs_clr = bus.wr_en && bus.wr_addr == bus.rs_addr
                 && !(bus.busy_set && bus.busy_addr == bus.rs_addr);
        rt_clr = bus.wr_en && bus.wr_addr == bus.rt_addr
                 && !(bus.busy_set && bus.busy_addr == bus.rt_addr);
        bus.stall = (busy[bus.rs_addr] && bus.rs_addr != '0 && !rs_clr)
                 || (busy[bus.rt_addr] && bus.rt_addr != '0 && !rt_clr);
    end
`else
    // Read muxes return stored contents only; register 0 is held at zero by the storage logic.
    always_comb begin
        bus.rs_data = regs[bus.rs_addr];
        bus.rt_data = regs[bus.rt_addr];
    end

    // Stall on any pending source operand.
    always_comb begin
        bus.stall = (busy[bus.rs_addr] && bus.rs_addr != '0)
                 || (busy[bus.rt_addr] && bus.rt_addr != '0);
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised + directed bench for regfile_sb with an array-based reference model and a scoreboard queue.
// Latency: checks combinational outputs each cycle at the falling edge.
// Backpressure: stall is checked as a plain output, stimulus does not wait on it.
module tb_regfile_sb;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int EXT = 25;
    localparam int MON = 24;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .EXT_REG(EXT), .MON_REG(MON)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          ext_en;
        logic [DW-1:0] ext_data;
        logic          bset;
        logic [AW-1:0] baddr;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
    } stim_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic          stall;
        logic [DW-1:0] mon;
    } exp_t;

    exp_t exp_q[$];

    // Reference state.
    logic [DW-1:0] m_regs [32];
    bit            m_busy [32];
    logic [DW-1:0] m_mon;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    function automatic stim_t mk(logic we, int wa, logic [DW-1:0] wd, logic ee, logic [DW-1:0] ed,
                                 logic bs, int ba, int rs, int rt);
        stim_t s;
        s.wr_en = we; s.wr_addr = AW'(wa); s.wr_data = wd;
        s.ext_en = ee; s.ext_data = ed;
        s.bset = bs; s.baddr = AW'(ba);
        s.rs = AW'(rs); s.rt = AW'(rt);
        return s;
    endfunction

    function automatic logic [DW-1:0] ref_read(int a, stim_t s);
`ifdef REGFILE_BYPASS_EN
        if (s.wr_en && s.wr_addr != 0 && int'(s.wr_addr) == a) return s.wr_data;
        if (s.ext_en && a == EXT && EXT != 0 && !(s.wr_en && int'(s.wr_addr) == EXT)) return s.ext_data;
`endif
        if (a == 0) return '0;
        return m_regs[a];
    endfunction

    function automatic bit ref_pending(int a, stim_t s);
        bit p;
        p = (a != 0) && m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (s.wr_en && int'(s.wr_addr) == a && !(s.bset && int'(s.baddr) == a)) p = 0;
`endif
        return p;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
        m_mon = '0;
    endfunction

    // Entered just after a rising edge; leaves just after the next one.
    task automatic run_cycle(input stim_t s);
        exp_t e;
        bus.wr_en = s.wr_en; bus.wr_addr = s.wr_addr; bus.wr_data = s.wr_data;
        bus.ext_wr_en = s.ext_en; bus.ext_wr_data = s.ext_data;
        bus.busy_set = s.bset; bus.busy_addr = s.baddr;
        bus.rs_addr = s.rs; bus.rt_addr = s.rt;
        if (!reset) model_clear();
        e.cyc     = cyc;
        e.rs_data = ref_read(int'(s.rs), s);
        e.rt_data = ref_read(int'(s.rt), s);
        e.stall   = ref_pending(int'(s.rs), s) || ref_pending(int'(s.rt), s);
        e.mon     = m_mon;
        exp_q.push_back(e);
        @(posedge clock);
        if (!reset) begin
            model_clear();
        end else begin
            m_mon = m_regs[MON];
            if (s.ext_en && EXT != 0) m_regs[EXT] = s.ext_data;
            if (s.wr_en && s.wr_addr != 0) m_regs[s.wr_addr] = s.wr_data;
            if (s.wr_en) m_busy[s.wr_addr] = 0;
            if (s.bset && s.baddr != 0) m_busy[s.baddr] = 1;
        end
        cyc++;
        #1;
    endtask

    function automatic int rnd_addr();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 0;
        if (r == 1) return MON;
        if (r == 2) return EXT;
        if (r == 3) return $urandom_range(8, 11);
        return $urandom_range(0, 31);
    endfunction

    // Scoreboard monitor: pops one expectation per cycle and compares away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.rs_data !== e.rs_data) begin
                    failures++;
                    $display("FAIL rs_data cyc=%0d got=%h exp=%h", e.cyc, bus.rs_data, e.rs_data);
                end
                checks++;
                if (bus.rt_data !== e.rt_data) begin
                    failures++;
                    $display("FAIL rt_data cyc=%0d got=%h exp=%h", e.cyc, bus.rt_data, e.rt_data);
                end
                checks++;
                if (bus.stall !== e.stall) begin
                    failures++;
                    $display("FAIL stall cyc=%0d got=%b exp=%b", e.cyc, bus.stall, e.stall);
                end
                checks++;
                if (bus.mon_data !== e.mon) begin
                    failures++;
                    $display("FAIL mon_data cyc=%0d got=%h exp=%h", e.cyc, bus.mon_data, e.mon);
                end
            end
        end
    end

    // Stimulus: directed scenarios first, then random traffic.
    initial begin
        stim_t idle;
        idle = mk(0, 0, '0, 0, '0, 0, 0, 0, 0);
        run_cycle(idle);
        model_clear();
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.ext_wr_en = 0; bus.ext_wr_data = '0;
        bus.busy_set = 0; bus.busy_addr = '0;
        bus.rs_addr = '0; bus.rt_addr = '0;
        @(posedge clock); #1;
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 5, 24));
        reset = 1'b1;

        // Build up state, then assert reset between edges.
        run_cycle(mk(1, 5, 32'hDEADBEEF, 0, '0, 0, 0, 5, 24));
        run_cycle(mk(1, 24, 32'h11111111, 0, '0, 1, 5, 5, 24));
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 5, 24));
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 5, 24));
        reset = 1'b0;
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 5, 24));
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 5, 24));
        reset = 1'b1;

        // Register 0 protection.
        run_cycle(mk(1, 0, 32'hFFFFFFFF, 0, '0, 0, 0, 0, 0));
        run_cycle(mk(0, 0, '0, 0, '0, 1, 0, 0, 0));
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 0, 0));

        // Write then read on both ports.
        run_cycle(mk(1, 8, 32'h12345678, 0, '0, 0, 0, 8, 8));
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 8, 8));

        // External channel and its priority against write-back.
        run_cycle(mk(0, 0, '0, 1, 32'hAAAA0000, 0, 0, 25, 8));
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 25, 8));
        run_cycle(mk(1, 25, 32'h00005555, 1, 32'h0000AAAA, 0, 0, 25, 25));
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 25, 25));

        // Scoreboard set, retire, and set-wins collision.
        run_cycle(mk(0, 0, '0, 0, '0, 1, 9, 0, 9));
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 0, 9));
        run_cycle(mk(1, 9, 32'h99, 0, '0, 0, 0, 0, 9));
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 0, 9));
        run_cycle(mk(0, 0, '0, 0, '0, 1, 9, 0, 9));
        run_cycle(mk(1, 9, 32'h77, 0, '0, 1, 9, 9, 9));
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 9, 0));
        run_cycle(mk(1, 9, 32'h78, 0, '0, 0, 0, 9, 0));
        run_cycle(mk(0, 0, '0, 1, 32'h1, 0, 0, 9, 25));

        // Monitor lag on MON_REG.
        run_cycle(mk(1, 24, 32'h42, 0, '0, 0, 0, 24, 0));
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 24, 0));
        run_cycle(mk(0, 0, '0, 0, '0, 0, 0, 24, 0));

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            stim_t s;
            s = mk($urandom_range(0, 1), rnd_addr(), $urandom(),
                   ($urandom_range(0, 3) == 0), $urandom(),
                   ($urandom_range(0, 9) < 3), rnd_addr(),
                   rnd_addr(), rnd_addr());
            run_cycle(s);
        end

        run_cycle(idle);
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
